idu_alu_issue: RTL and testbench
================================

Name: idu_alu_issue

Overview:
Decode/issue stage that produces the ALU-side interface (alu_ctrl, src1, src2) consumed by the execute stage. It accepts RV32I instructions from the fetch unit over a valid/ready handshake and reads register operands through a combinational register-file port. It decodes into the team's 5-bit ALU opcode plus operand selection and holds the result in a single-entry output register with valid/ready backpressure and flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC_TAG, 32'h0, value driven on out_pc while out_valid is 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard the held and incoming instruction (redirect)
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept
in_inst  in  32  instruction word
in_pc  in  32  instruction address
rs1_addr  out  5  regfile read address, combinational from in_inst[19:15]
rs2_addr  out  5  regfile read address, combinational from in_inst[24:20]
rs1_data  in  32  combinational read data
rs2_data  in  32  combinational read data
out_valid  out  1  issued op valid
out_ready  in  1  execute accepts
out_alu_ctrl  out  5  ALU opcode
out_src1  out  32  ALU operand 1
out_src2  out  32  ALU operand 2
out_imm  out  32  sign-extended immediate (branch offset, store offset)
out_store_data  out  32  rs2_data for stores
out_pc  out  32  instruction PC
out_rd  out  5  destination register
out_rd_wen  out  1  writeback enable; forced to 0 when rd = 0
out_kind  out  3  0 ALU, 1 BRANCH, 2 JAL, 3 JALR, 4 LOAD, 5 STORE
out_illegal  out  1  unsupported encoding

Behaviour:
- ALU opcodes: 00000 ADD; 00001 pass src2; 00010 SUB; 00011 (src1+src2)&~1; 00100 SLTU; 00101 XOR; 00110 OR; 00111 AND; 01000 SLL; 01001 SRA; 01010 SRL; 01100 SLT; 01101 EQ; 01110 GE; 01111 GEU; 10000 LT; 10001 LTU; 10010 NE.
- Reset (rst_n low, asynchronous): out_valid=0. All payload outputs are 0, except out_pc, which takes RESET_PC_TAG.
- Output register: in_ready = !out_valid || out_ready (combinational).
  - Accept on in_valid && in_ready && !flush. The decoded payload is registered and out_valid=1 on the next edge (latency 1).
  - If out_valid && out_ready with no accept, out_valid clears.
  - While out_valid && !out_ready, the payload holds stable.
- Flush: out_valid=0 on the next edge. A same-cycle accept is dropped. Flush has priority over everything except reset.
- Decode, by opcode:
  - OP-IMM: src1=rs1, src2=sext(I). funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - OP-IMM shifts: slli/srli/srai use src2={27'b0,shamt}. slli and srli require funct7=0000000; srai requires funct7=0100000. Any other funct7 is illegal.
  - OP: src2=rs2, same funct3 map. funct7 0100000 selects SUB (funct3 000) or SRA (funct3 101). Other funct7 values are illegal.
  - LUI: opcode 00001, src2={U,12'b0}.
  - AUIPC: ADD, src1=pc, src2=U-immediate.
  - JAL: ADD, src1=pc, src2=sext(J); kind 2.
  - JALR: 00011, src1=rs1, src2=sext(I); kind 3.
  - BRANCH: src1=rs1, src2=rs2, out_imm=sext(B); kind 1; rd_wen=0. funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Funct3 010/011 is illegal.
  - LOAD: ADD rs1+sext(I); kind 4.
  - STORE: ADD rs1+sext(S); kind 5; out_imm=sext(S); store_data=rs2; rd_wen=0.
- Illegal instructions: opcode 00000, rd_wen=0, kind 0, out_illegal=1. The op still issues normally through the handshake.
- rs1/rs2 data are sampled only on the accept edge.

Test Plan:
- Reset mid-stream: hold out_valid=1, assert rst_n=0 asynchronously -> out_valid=0 and payload 0 before the next clk edge; in_ready=1.
- addi x5,x1,-1 (32'hFFF08293), rs1_data=7 -> next cycle: out_alu_ctrl=00000, src1=7, src2=32'hFFFFFFFF, rd=5, rd_wen=1, kind 0.
- Backpressure: hold out_ready=0 for 3 cycles after issuing sub x3,x1,x2 (32'h402081B3) -> in_ready=0 and payload stable throughout. Release -> a second instruction accepted the same cycle issues the following cycle.
- bne x1,x2,+8 (32'h00209463) -> ctrl 10010, out_imm=8, rd_wen=0, kind 1. Then addi x0,x0,0 -> rd_wen=0.
- Flush while in_valid=1 and out_valid=1 -> out_valid=0 next cycle and the incoming instruction never appears.
- Illegal inputs: srai with funct7=0000001 and opcode 7'b1111111 -> out_illegal=1, ctrl 00000, rd_wen=0. Also check jalr (ctrl 00011) and lui 32'h12345 (src2=32'h12345000).

Source files
------------

// File: rtl/idu_alu_issue.sv
// idu_alu_issue: RV32I decode/issue stage feeding the ALU-side execute interface.
// Decodes one instruction per handshake into ALU opcode, operands and control,
// and holds the result in a single-entry output register with backpressure and flush.
module idu_alu_issue #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_alu_ctrl,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen,
    output logic [2:0]      out_kind,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_PASS2 = 5'b00001;
    localparam logic [4:0] ALU_SUB   = 5'b00010;
    localparam logic [4:0] ALU_JALR  = 5'b00011;
    localparam logic [4:0] ALU_SLTU  = 5'b00100;
    localparam logic [4:0] ALU_XOR   = 5'b00101;
    localparam logic [4:0] ALU_OR    = 5'b00110;
    localparam logic [4:0] ALU_AND   = 5'b00111;
    localparam logic [4:0] ALU_SLL   = 5'b01000;
    localparam logic [4:0] ALU_SRA   = 5'b01001;
    localparam logic [4:0] ALU_SRL   = 5'b01010;
    localparam logic [4:0] ALU_SLT   = 5'b01100;
    localparam logic [4:0] ALU_EQ    = 5'b01101;
    localparam logic [4:0] ALU_GE    = 5'b01110;
    localparam logic [4:0] ALU_GEU   = 5'b01111;
    localparam logic [4:0] ALU_LT    = 5'b10000;
    localparam logic [4:0] ALU_LTU   = 5'b10001;
    localparam logic [4:0] ALU_NE    = 5'b10010;

    localparam logic [2:0] KIND_ALU    = 3'd0;
    localparam logic [2:0] KIND_BRANCH = 3'd1;
    localparam logic [2:0] KIND_JAL    = 3'd2;
    localparam logic [2:0] KIND_JALR   = 3'd3;
    localparam logic [2:0] KIND_LOAD   = 3'd4;
    localparam logic [2:0] KIND_STORE  = 3'd5;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    logic [4:0]      d_ctrl;
    logic [XLEN-1:0] d_src1, d_src2, d_imm, d_store_data;
    logic [2:0]      d_kind;
    logic            d_writes, d_illegal;

    logic            valid_q;
    logic            accept;
    logic [XLEN-1:0] pc_q;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rd       = in_inst[11:7];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign shamt = {{(XLEN-5){1'b0}}, in_inst[24:20]};

    // funct3 -> ALU opcode for the shared OP / OP-IMM arithmetic map
    function automatic logic [4:0] arith_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  arith_ctrl = ALU_ADD;
            3'b001:  arith_ctrl = ALU_SLL;
            3'b010:  arith_ctrl = ALU_SLT;
            3'b011:  arith_ctrl = ALU_SLTU;
            3'b100:  arith_ctrl = ALU_XOR;
            3'b101:  arith_ctrl = ALU_SRL;
            3'b110:  arith_ctrl = ALU_OR;
            default: arith_ctrl = ALU_AND;
        endcase
    endfunction

    // Instruction decode into ALU opcode, operand selection and control
    always_comb begin
        d_ctrl       = ALU_ADD;
        d_src1       = '0;
        d_src2       = '0;
        d_imm        = '0;
        d_store_data = '0;
        d_kind       = KIND_ALU;
        d_writes     = 1'b0;
        d_illegal    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                d_src1   = rs1_data;
                d_src2   = imm_i;
                d_imm    = imm_i;
                d_writes = 1'b1;
                d_ctrl   = arith_ctrl(funct3);
                if (funct3 == 3'b001) begin
                    d_src2    = shamt;
                    d_illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    d_src2 = shamt;
                    if (funct7 == 7'b0100000)
                        d_ctrl = ALU_SRA;
                    else if (funct7 != 7'b0000000)
                        d_illegal = 1'b1;
                end
            end
            OPC_OP: begin
                d_src1   = rs1_data;
                d_src2   = rs2_data;
                d_writes = 1'b1;
                if (funct7 == 7'b0000000) begin
                    d_ctrl = arith_ctrl(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    d_ctrl = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    d_ctrl = ALU_SRA;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                d_ctrl   = ALU_PASS2;
                d_src2   = imm_u;
                d_imm    = imm_u;
                d_writes = 1'b1;
            end
            OPC_AUIPC: begin
                d_src1   = in_pc;
                d_src2   = imm_u;
                d_imm    = imm_u;
                d_writes = 1'b1;
            end
            OPC_JAL: begin
                d_src1   = in_pc;
                d_src2   = imm_j;
                d_imm    = imm_j;
                d_kind   = KIND_JAL;
                d_writes = 1'b1;
            end
            OPC_JALR: begin
                d_ctrl   = ALU_JALR;
                d_src1   = rs1_data;
                d_src2   = imm_i;
                d_imm    = imm_i;
                d_kind   = KIND_JALR;
                d_writes = 1'b1;
            end
            OPC_BRANCH: begin
                d_src1 = rs1_data;
                d_src2 = rs2_data;
                d_imm  = imm_b;
                d_kind = KIND_BRANCH;
                case (funct3)
                    3'b000:  d_ctrl = ALU_EQ;
                    3'b001:  d_ctrl = ALU_NE;
                    3'b100:  d_ctrl = ALU_LT;
                    3'b101:  d_ctrl = ALU_GE;
                    3'b110:  d_ctrl = ALU_LTU;
                    3'b111:  d_ctrl = ALU_GEU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_src1   = rs1_data;
                d_src2   = imm_i;
                d_imm    = imm_i;
                d_kind   = KIND_LOAD;
                d_writes = 1'b1;
            end
            OPC_STORE: begin
                d_src1       = rs1_data;
                d_src2       = imm_s;
                d_imm        = imm_s;
                d_store_data = rs2_data;
                d_kind       = KIND_STORE;
            end
            default: d_illegal = 1'b1;
        endcase
        // Illegal ops still travel down the pipe but carry a neutral payload
        if (d_illegal) begin
            d_ctrl       = ALU_ADD;
            d_src1       = '0;
            d_src2       = '0;
            d_imm        = '0;
            d_store_data = '0;
            d_kind       = KIND_ALU;
            d_writes     = 1'b0;
        end
    end

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = valid_q;
    assign out_pc    = valid_q ? pc_q : RESET_PC_TAG;

    // Output-slot occupancy: flush wins, then accept, then drain on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= 1'b0;
        else if (flush)
            valid_q <= 1'b0;
        else if (accept)
            valid_q <= 1'b1;
        else if (out_ready)
            valid_q <= 1'b0;
    end

    // Payload captured only on accept so it stays stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_alu_ctrl   <= '0;
            out_src1       <= '0;
            out_src2       <= '0;
            out_imm        <= '0;
            out_store_data <= '0;
            pc_q           <= '0;
            out_rd         <= '0;
            out_rd_wen     <= 1'b0;
            out_kind       <= '0;
            out_illegal    <= 1'b0;
        end else if (accept) begin
            out_alu_ctrl   <= d_ctrl;
            out_src1       <= d_src1;
            out_src2       <= d_src2;
            out_imm        <= d_imm;
            out_store_data <= d_store_data;
            pc_q           <= in_pc;
            out_rd         <= rd;
            out_rd_wen     <= d_writes && (rd != 5'd0);
            out_kind       <= d_kind;
            out_illegal    <= d_illegal;
        end
    end

endmodule

// File: tb/tb_idu_alu_issue.sv
// Scoreboard bench for idu_alu_issue: directed instructions with hand-computed
// expected payloads; a negedge monitor pops and compares on every output transfer.
module tb_idu_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_alu_ctrl;
    logic [31:0] out_src1, out_src2, out_imm, out_store_data, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [2:0]  out_kind;
    logic        out_illegal;

    idu_alu_issue #(.XLEN(32), .RESET_PC_TAG(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl),
        .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd),
        .out_rd_wen(out_rd_wen), .out_kind(out_kind), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] src1, src2, imm, sd, pc;
        logic [4:0]  rd;
        logic        wen;
        logic [2:0]  kind;
        logic        ill;
        bit          c1, c2, ci, csd, crd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] ctrl, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] imm, input logic [31:0] sd, input logic [31:0] pc,
                                input logic [4:0] rd, input logic wen, input logic [2:0] kind,
                                input logic ill, input bit c1, input bit c2, input bit ci,
                                input bit csd, input bit crd);
        exp_t e;
        e.ctrl = ctrl; e.src1 = s1; e.src2 = s2; e.imm = imm; e.sd = sd; e.pc = pc;
        e.rd = rd; e.wen = wen; e.kind = kind; e.ill = ill;
        e.c1 = c1; e.c2 = c2; e.ci = ci; e.csd = csd; e.crd = crd;
        return e;
    endfunction

    // Monitor: compare every transfer against the scoreboard, and check payload stability while stalled
    logic        stall_prev = 1'b0;
    logic [4:0]  snap_ctrl;
    logic [31:0] snap_src1, snap_src2, snap_pc;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && stall_prev && out_valid) begin
            check("stable_ctrl", {27'b0, out_alu_ctrl}, {27'b0, snap_ctrl});
            check("stable_src1", out_src1, snap_src1);
            check("stable_src2", out_src2, snap_src2);
            check("stable_pc", out_pc, snap_pc);
        end
        stall_prev = rst_n && out_valid && !out_ready;
        snap_ctrl  = out_alu_ctrl;
        snap_src1  = out_src1;
        snap_src2  = out_src2;
        snap_pc    = out_pc;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("alu_ctrl", {27'b0, out_alu_ctrl}, {27'b0, e.ctrl});
                check("pc", out_pc, e.pc);
                check("rd_wen", {31'b0, out_rd_wen}, {31'b0, e.wen});
                check("kind", {29'b0, out_kind}, {29'b0, e.kind});
                check("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
                if (e.c1)  check("src1", out_src1, e.src1);
                if (e.c2)  check("src2", out_src2, e.src2);
                if (e.ci)  check("imm", out_imm, e.imm);
                if (e.csd) check("store_data", out_store_data, e.sd);
                if (e.crd) check("rd", {27'b0, out_rd}, {27'b0, e.rd});
            end
        end
    end

    // Present one instruction, wait (bounded) for acceptance, then return 1 ns after the accept edge
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                check("accept_timeout_pc", pc, 32'hFFFF_FFFF);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1_data = 32'hDEAD_BEEF;
        rs2_data = 32'hBAAD_F00D;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = 32'h0; in_pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_src1", out_src1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // addi x5,x1,-1 with one-cycle latency
        issue(32'hFFF08293, 32'h100, 32'd7, 32'd0,
              mk(5'b00000, 32'd7, 32'hFFFF_FFFF, 0, 0, 32'h100, 5'd5, 1, 3'd0, 0, 1, 1, 0, 0, 1));
        check("addi_latency_valid", {31'b0, out_valid}, 32'd1);
        idle(2);

        // sub held for three stall cycles, then xor accepted on the release cycle
        out_ready = 1'b0;
        issue(32'h402081B3, 32'h104, 32'd100, 32'd30,
              mk(5'b00010, 32'd100, 32'd30, 0, 0, 32'h104, 5'd3, 1, 3'd0, 0, 1, 1, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(32'h0020C233, 32'h108, 32'h0000_F0F0, 32'h0000_0FF0,
              mk(5'b00101, 32'h0000_F0F0, 32'h0000_0FF0, 0, 0, 32'h108, 5'd4, 1, 3'd0, 0, 1, 1, 0, 0, 1));
        check("release_next_valid", {31'b0, out_valid}, 32'd1);
        check("release_next_pc", out_pc, 32'h108);

        // bne x1,x2,+8 then addi x0,x0,0
        in_inst = 32'h00209463;
        #1;
        check("rs1_addr", {27'b0, rs1_addr}, 32'd1);
        check("rs2_addr", {27'b0, rs2_addr}, 32'd2);
        issue(32'h00209463, 32'h10C, 32'h11, 32'h22,
              mk(5'b10010, 32'h11, 32'h22, 32'd8, 0, 32'h10C, 5'd0, 0, 3'd1, 0, 1, 1, 1, 0, 0));
        issue(32'h00000013, 32'h110, 32'd0, 32'd0,
              mk(5'b00000, 32'd0, 32'd0, 0, 0, 32'h110, 5'd0, 0, 3'd0, 0, 1, 1, 0, 0, 1));
        idle(2);

        // Flush with a held op and a new incoming op: neither may appear
        out_ready = 1'b0;
        issue(32'h00100313, 32'h114, 32'd0, 32'd0,
              mk(5'b00000, 32'd0, 32'd1, 0, 0, 32'h114, 5'd6, 1, 3'd0, 0, 1, 1, 0, 0, 1));
        void'(exp_q.pop_back());
        in_valid = 1'b1; in_inst = 32'h0020C233; in_pc = 32'h118; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        idle(2);
        check("flush_stays_empty", {31'b0, out_valid}, 32'd0);
        issue(32'h0F00F413, 32'h11C, 32'h0000_ABCD, 32'd0,
              mk(5'b00111, 32'h0000_ABCD, 32'h0000_00F0, 0, 0, 32'h11C, 5'd8, 1, 3'd0, 0, 1, 1, 0, 0, 1));

        // Back-to-back: illegal encodings and assorted legal formats
        issue(32'h02315093, 32'h120, 32'd5, 32'd0,
              mk(5'b00000, 0, 0, 0, 0, 32'h120, 5'd0, 0, 3'd0, 1, 0, 0, 0, 0, 0));
        issue(32'h000002FF, 32'h124, 32'd5, 32'd0,
              mk(5'b00000, 0, 0, 0, 0, 32'h124, 5'd0, 0, 3'd0, 1, 0, 0, 0, 0, 0));
        issue(32'h004280E7, 32'h128, 32'h1000, 32'd0,
              mk(5'b00011, 32'h1000, 32'd4, 0, 0, 32'h128, 5'd1, 1, 3'd3, 0, 1, 1, 0, 0, 1));
        issue(32'h123453B7, 32'h12C, 32'd9, 32'd0,
              mk(5'b00001, 0, 32'h1234_5000, 0, 0, 32'h12C, 5'd7, 1, 3'd0, 0, 0, 1, 0, 0, 1));
        issue(32'h0020A623, 32'h130, 32'h2000, 32'hCAFE_BABE,
              mk(5'b00000, 32'h2000, 32'd12, 32'd12, 32'hCAFE_BABE, 32'h130, 5'd0, 0, 3'd5, 0, 1, 1, 1, 1, 0));
        issue(32'h00001517, 32'h134, 32'd0, 32'd0,
              mk(5'b00000, 32'h134, 32'h1000, 0, 0, 32'h134, 5'd10, 1, 3'd0, 0, 1, 1, 0, 0, 1));
        issue(32'h010000EF, 32'h138, 32'd0, 32'd0,
              mk(5'b00000, 32'h138, 32'd16, 0, 0, 32'h138, 5'd1, 1, 3'd2, 0, 1, 1, 0, 0, 1));
        issue(32'h01F09293, 32'h13C, 32'd3, 32'd0,
              mk(5'b01000, 32'd3, 32'd31, 0, 0, 32'h13C, 5'd5, 1, 3'd0, 0, 1, 1, 0, 0, 1));
        issue(32'h0020A463, 32'h140, 32'd1, 32'd2,
              mk(5'b00000, 0, 0, 0, 0, 32'h140, 5'd0, 0, 3'd1 - 3'd1, 1, 0, 0, 0, 0, 0));
        idle(3);
        check("drain_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset while an op is held
        out_ready = 1'b0;
        issue(32'h010000EF, 32'h144, 32'd0, 32'd0,
              mk(5'b00000, 32'h144, 32'd16, 0, 0, 32'h144, 5'd1, 1, 3'd2, 0, 1, 1, 0, 0, 1));
        check("held_before_reset", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("async_rst_pc", out_pc, 32'h0);
        check("async_rst_src2", out_src2, 32'h0);
        check("async_rst_rd", {27'b0, out_rd}, 32'd0);
        check("async_rst_kind", {29'b0, out_kind}, 32'd0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(3);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
